// File: rtl/ram_stream_reader_pkg.sv
// Shared constants for the RAM stream reader.
//   state_t / St*  : controller states (IDLE, ISSUE, DRAIN), plain encoded constants
//   FIFO_DEPTH     : output buffer depth, which is also the cap on reads in flight
package ram_reader_pkg;

   localparam int unsigned FIFO_DEPTH = 4;

   typedef logic [1:0] state_t;

   localparam state_t StIdle  = 2'd0;
   localparam state_t StIssue = 2'd1;
   localparam state_t StDrain = 2'd2;

endpackage

// File: rtl/ram_stream_reader_if.sv
// Bundle of command, status, RAM read-port and output-stream signals.
//   master : the reader (drives busy/done/mem_addr/m_valid/m_data/m_last)
//   slave  : the environment (drives start/base_addr/length/mem_dout/m_ready)
interface ram_stream_reader_if #(
   parameter int unsigned ADDRESS_WIDTH = 8,
   parameter int unsigned DATA_WIDTH    = 8
);

   logic                     start;
   logic [ADDRESS_WIDTH-1:0] base_addr;
   logic [ADDRESS_WIDTH:0]   length;
   logic                     busy;
   logic                     done;
   logic [ADDRESS_WIDTH-1:0] mem_addr;
   logic [DATA_WIDTH-1:0]    mem_dout;
   logic                     m_valid;
   logic                     m_ready;
   logic [DATA_WIDTH-1:0]    m_data;
   logic                     m_last;

   modport master (
      input  start, base_addr, length, mem_dout, m_ready,
      output busy, done, mem_addr, m_valid, m_data, m_last
   );

   modport slave (
      output start, base_addr, length, mem_dout, m_ready,
      input  busy, done, mem_addr, m_valid, m_data, m_last
   );

endinterface

// File: rtl/ram_stream_reader_stream_fifo.sv
// Small synchronous FIFO holding returned words plus their last flag.
//   clock, reset       : posedge clock, synchronous active-high reset
//   push, push_data    : write side (ignored when full)
//   pop, pop_data      : read side, pop_data is the current head (ignored when empty)
//   full, empty, count : occupancy status
// DEPTH must be a power of two so the pointers wrap naturally.
module stream_fifo
   import ram_reader_pkg::*;
#(
   parameter int unsigned WIDTH = 9,
   parameter int unsigned DEPTH = FIFO_DEPTH
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         push,
   input  logic [WIDTH-1:0]             push_data,
   input  logic                         pop,
   output logic [WIDTH-1:0]             pop_data,
   output logic                         full,
   output logic                         empty,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int unsigned PtrW   = $clog2(DEPTH);
   localparam int unsigned CountW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0]  mem_q [DEPTH];
   logic [PtrW-1:0]   wr_ptr_q;
   logic [PtrW-1:0]   rd_ptr_q;
   logic [CountW-1:0] count_q;
   logic              do_push;
   logic              do_pop;

   assign empty    = (count_q == '0);
   assign full     = (count_q == CountW'(DEPTH));
   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;
   assign pop_data = mem_q[rd_ptr_q];
   assign count    = count_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         // Storage is cleared too so the head reads as zero after reset.
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
            wr_ptr_q        <= wr_ptr_q + PtrW'(1);
         end
         if (do_pop) begin
            rd_ptr_q <= rd_ptr_q + PtrW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + CountW'(1);
            2'b01:   count_q <= count_q - CountW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/ram_stream_reader.sv
// Read-port initiator for registered-read (1-cycle latency) RAMs.
//   clock, reset : posedge clock, synchronous active-high reset
//   bus.master   : start/base_addr/length command, busy/done status,
//                  mem_addr/mem_dout RAM read port, m_valid/m_ready/m_data/m_last stream
// Walks length words from base_addr (wrapping), buffers returned words in a
// 4-entry FIFO and never has more than 4 reads outstanding, so backpressure
// stalls issuing instead of overflowing the buffer.
module ram_stream_reader
   import ram_reader_pkg::*;
#(
   parameter int unsigned ADDRESS_WIDTH = 8,
   parameter int unsigned DATA_WIDTH    = 8
) (
   input logic               clock,
   input logic               reset,
   ram_stream_reader_if.master bus
);

   localparam int unsigned CountW = $clog2(FIFO_DEPTH + 1);

   state_t                   state_q;
   logic [ADDRESS_WIDTH:0]   issue_cnt_q;
   logic [ADDRESS_WIDTH-1:0] addr_q;
   logic                     rd_valid_q;
   logic                     rd_last_q;
   logic                     done_q;

   logic                     issue;
   logic                     last_issue;
   logic [CountW:0]          outstanding;
   logic [CountW-1:0]        fifo_count;
   logic                     fifo_full;
   logic                     fifo_empty;
   logic                     pop;
   logic [DATA_WIDTH:0]      fifo_head;

   // Reads already in flight: buffered words plus the word returning this cycle.
   // Issuing only below the depth keeps the total, including this issue, within 4.
   assign outstanding = {1'b0, fifo_count} + {{CountW{1'b0}}, rd_valid_q};

   always_comb begin
      issue      = (state_q == StIssue) && (outstanding < (CountW + 1)'(FIFO_DEPTH));
      last_issue = issue && (issue_cnt_q == (ADDRESS_WIDTH + 1)'(1));
   end

   assign pop = bus.m_valid && bus.m_ready;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= StIdle;
         issue_cnt_q <= '0;
         addr_q      <= '0;
         rd_valid_q  <= 1'b0;
         rd_last_q   <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         done_q     <= 1'b0;
         // mem_dout is valid the cycle after the address was issued.
         rd_valid_q <= issue;
         rd_last_q  <= last_issue;
         case (state_q)
            StIdle: begin
               if (bus.start) begin
                  if (bus.length != '0) begin
                     state_q     <= StIssue;
                     addr_q      <= bus.base_addr;
                     issue_cnt_q <= bus.length;
                  end else begin
                     done_q <= 1'b1;
                  end
               end
            end
            StIssue: begin
               if (issue) begin
                  addr_q      <= addr_q + ADDRESS_WIDTH'(1);
                  issue_cnt_q <= issue_cnt_q - (ADDRESS_WIDTH + 1)'(1);
                  if (last_issue) begin
                     state_q <= StDrain;
                  end
               end
            end
            StDrain: begin
               if (pop && bus.m_last) begin
                  state_q <= StIdle;
                  done_q  <= 1'b1;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   stream_fifo #(
      .WIDTH (DATA_WIDTH + 1),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (rd_valid_q && !fifo_full),
      .push_data ({rd_last_q, bus.mem_dout}),
      .pop       (pop),
      .pop_data  (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   assign bus.busy                = (state_q != StIdle);
   assign bus.done                = done_q;
   assign bus.mem_addr            = addr_q;
   assign bus.m_valid             = !fifo_empty;
   assign {bus.m_last, bus.m_data} = fifo_head;

endmodule

// File: tb/tb_ram_stream_reader.sv
// Self-checking bench for ram_stream_reader with a 16-word RAM holding 100+i.
module tb_ram_stream_reader;

   localparam int unsigned AW = 4;
   localparam int unsigned DW = 8;

   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   ram_stream_reader_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   ram_stream_reader #(
      .ADDRESS_WIDTH (AW),
      .DATA_WIDTH    (DW)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   // Registered-read RAM: ram[i] = 100 + i.
   always @(posedge clock) bus.mem_dout <= 8'(100 + 32'(bus.mem_addr));

   typedef struct {
      logic [7:0] data;
      logic       last;
   } beat_t;

   typedef struct {
      int base;
      int len;
      int rmode;      // 0: always ready, 1: random, 2: 6-cycle stall then random
      bit poke;       // pulse a competing start while busy
      int exp_first;
      int exp_final;
      int exp_end;    // mem_addr once the transfer is done
   } vec_t;

   beat_t exp_q[$];
   beat_t hb;
   vec_t  vecs[10];

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int t0 = 0;
   int ready_mode = 0;
   int last_hs_cyc = -10;
   int last_hs_data = -1;
   int adv = 0;
   int pops = 0;
   bit mon_en = 1'b0;

   logic       prev_valid = 1'b0;
   logic       prev_ready = 1'b0;
   logic       prev_last = 1'b0;
   logic       prev_busy = 1'b0;
   logic [7:0] prev_data = '0;
   logic [3:0] prev_addr = '0;

   always @(posedge clock) cyc++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Consumer ready, changed just after each rising edge.
   always @(posedge clock) begin
      #1;
      case (ready_mode)
         0:       bus.m_ready = 1'b1;
         1:       bus.m_ready = ($urandom_range(0, 3) != 0);
         default: bus.m_ready = (cyc - t0 < 5) ? 1'b1 :
                                (cyc - t0 < 11) ? 1'b0 : ($urandom_range(0, 1) == 1);
      endcase
   end

   // Stream scoreboard, stall stability and outstanding-read bound.
   always @(negedge clock) begin
      if (reset || !mon_en) begin
         prev_valid = 1'b0;
         prev_busy  = 1'b0;
         adv        = 0;
         pops       = 0;
      end else begin
         if (prev_valid && !prev_ready) begin
            check("stall_valid", 32'(bus.m_valid), 1);
            check("stall_data", 32'(bus.m_data), 32'(prev_data));
            check("stall_last", 32'(bus.m_last), 32'(prev_last));
         end
         if (bus.busy && prev_busy && bus.mem_addr == 4'(prev_addr + 4'd1)) adv++;
         if (bus.busy) check("outstanding_over_4", 32'(adv - pops > 4), 0);
         if (bus.m_valid && bus.m_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_beat: got data %0d, expected no beat", bus.m_data);
            end else begin
               hb = exp_q.pop_front();
               check("beat_data", 32'(bus.m_data), 32'(hb.data));
               check("beat_last", 32'(bus.m_last), 32'(hb.last));
            end
            if (bus.m_last) begin
               last_hs_cyc  = cyc;
               last_hs_data = int'(bus.m_data);
            end
            pops++;
         end
         prev_valid = bus.m_valid;
         prev_ready = bus.m_ready;
         prev_data  = bus.m_data;
         prev_last  = bus.m_last;
         prev_busy  = bus.busy;
      end
      prev_addr = bus.mem_addr;
   end

   task automatic run_vec(input vec_t v);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < v.len; i++) begin
         exp_q.push_back('{data: 8'(100 + (v.base + i) % 16), last: (i == v.len - 1)});
      end
      ready_mode = v.rmode;
      @(posedge clock); #1;
      t0 = cyc;
      bus.start     = 1'b1;
      bus.base_addr = 4'(v.base);
      bus.length    = 5'(v.len);
      for (int n = 1; n <= 300 && !seen; n++) begin
         @(posedge clock); #1;
         bus.start = 1'b0;
         if (v.poke && n == 2) begin
            bus.start     = 1'b1;
            bus.base_addr = 4'd9;
            bus.length    = 5'd5;
         end
         if (v.len > 0 && v.rmode == 0 && n <= v.len)
            check("addr_seq", 32'(bus.mem_addr), 32'((v.base + n - 1) % 16));
         if (n == 2) check("valid_T2", 32'(bus.m_valid), 0);
         if (n == 3 && v.len > 0) begin
            check("valid_T3", 32'(bus.m_valid), 1);
            check("data_T3", 32'(bus.m_data), 32'(v.exp_first));
         end
         if (bus.done) begin
            seen = 1'b1;
            check("busy_at_done", 32'(bus.busy), 0);
            if (v.len == 0) begin
               check("done_latency_len0", 32'(n), 1);
            end else begin
               check("done_after_last", 32'(cyc), 32'(last_hs_cyc + 1));
               check("final_data", 32'(last_hs_data), 32'(v.exp_final));
               if (v.rmode == 0) check("done_latency", 32'(n), 32'(v.len + 3));
               check("end_addr", 32'(bus.mem_addr), 32'(v.exp_end));
               check("queue_drained", 32'(exp_q.size()), 0);
            end
         end else if (v.len > 0) begin
            check("busy_during", 32'(bus.busy), 1);
         end
      end
      if (!seen) begin
         checks++;
         errors++;
         $display("FAIL done_timeout: got no done, expected done within 300 cycles");
         exp_q.delete();
      end
      @(posedge clock); #1;
      check("done_one_cycle", 32'(bus.done), 0);
      check("valid_after", 32'(bus.m_valid), 0);
      check("busy_after", 32'(bus.busy), 0);
   endtask

   initial begin
      int b;
      int l;
      vecs[0] = '{2, 4, 0, 0, 102, 105, 6};
      vecs[1] = '{14, 4, 0, 0, 114, 101, 2};
      vecs[2] = '{0, 10, 2, 0, 100, 109, 10};
      vecs[3] = '{0, 0, 0, 0, 0, 0, 0};
      vecs[4] = '{0, 16, 0, 0, 100, 115, 0};
      vecs[5] = '{3, 6, 0, 1, 103, 108, 9};
      for (int i = 6; i < 10; i++) begin
         b = int'($urandom_range(0, 15));
         l = int'($urandom_range(1, 16));
         vecs[i] = '{b, l, 1, 0, 100 + b, 100 + (b + l - 1) % 16, (b + l) % 16};
      end

      reset         = 1'b1;
      bus.start     = 1'b0;
      bus.base_addr = '0;
      bus.length    = '0;
      repeat (3) begin
         @(posedge clock); #1;
      end
      check("rst_busy", 32'(bus.busy), 0);
      check("rst_done", 32'(bus.done), 0);
      check("rst_valid", 32'(bus.m_valid), 0);
      check("rst_last", 32'(bus.m_last), 0);
      check("rst_data", 32'(bus.m_data), 0);
      check("rst_addr", 32'(bus.mem_addr), 0);
      reset  = 1'b0;
      mon_en = 1'b1;

      for (int i = 0; i < 10; i++) run_vec(vecs[i]);

      // Reset two cycles into a length-8 transfer: everything discarded, no done.
      mon_en     = 1'b0;
      ready_mode = 0;
      @(posedge clock); #1;
      bus.start     = 1'b1;
      bus.base_addr = 4'd0;
      bus.length    = 5'd8;
      @(posedge clock); #1;
      bus.start = 1'b0;
      @(posedge clock); #1;
      reset = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
      check("midrst_busy", 32'(bus.busy), 0);
      check("midrst_done", 32'(bus.done), 0);
      check("midrst_valid", 32'(bus.m_valid), 0);
      check("midrst_last", 32'(bus.m_last), 0);
      check("midrst_data", 32'(bus.m_data), 0);
      check("midrst_addr", 32'(bus.mem_addr), 0);
      for (int i = 0; i < 5; i++) begin
         @(posedge clock); #1;
         check("midrst_no_done", 32'(bus.done), 0);
         check("midrst_no_valid", 32'(bus.m_valid), 0);
      end
      mon_en = 1'b1;
      run_vec('{5, 2, 0, 0, 105, 106, 7});

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ram_stream_reader.md
# ram_stream_reader

Read-port initiator for the team's registered-read (read-first style, 1-cycle latency) single-port-read RAMs. On a start command it walks a contiguous, wrapping address range, drives the RAM read address, captures returned words and presents them as a valid/ready stream with a last-beat marker. It sits between any synchronous RAM read port and a streaming consumer, and absorbs consumer backpressure without dropping or duplicating words.

## Interface
- ADDRESS_WIDTH, 8, RAM address width; range wraps modulo 2**ADDRESS_WIDTH
- DATA_WIDTH, 8, RAM/stream word width
- clock  in  1  single clock, all logic on posedge
- reset  in  1  synchronous, active-high
- start  in  1  command strobe, accepted only in IDLE
- base_addr  in  ADDRESS_WIDTH  first read address
- length  in  ADDRESS_WIDTH+1  word count, 0..2**ADDRESS_WIDTH
- busy  out  1  transfer in progress
- done  out  1  one-cycle completion pulse
- mem_addr  out  ADDRESS_WIDTH  registered RAM read address
- mem_dout  in  DATA_WIDTH  RAM registered read data, valid 1 cycle after mem_addr sampled
- m_valid  out  1  stream word valid
- m_ready  in  1  consumer ready
- m_data  out  DATA_WIDTH  stream word
- m_last  out  1  marks final word of the transfer

## Operation
- States: IDLE, ISSUE, DRAIN.
- IDLE: start=1 with length>0 -> ISSUE, busy=1, mem_addr<=base_addr, issue counter<=length. start=1 with length=0 -> stay IDLE, done=1 next cycle, busy stays 0.
- ISSUE: one read issued per cycle while outstanding<4 (outstanding = FIFO occupancy + reads in the 2-stage address/data pipeline). Each issue: mem_addr increments mod 2**ADDRESS_WIDTH, issue counter decrements. Last read issued -> DRAIN.
- Pipeline: issue flag delayed 1 cycle marks mem_dout valid; that cycle mem_dout and a last flag are pushed into a 4-entry FIFO.
- Stream: m_valid = FIFO non-empty; m_data/m_last = FIFO head; pop on m_valid&m_ready.
- DRAIN: waits until the last-flagged word handshakes -> IDLE, done=1 for one cycle, busy=0 in that same cycle.
- start while busy: ignored, no effect on the current transfer.
- When not issuing, mem_addr holds its value.
- Counter widths: issue/remaining counters ADDRESS_WIDTH+1 bits so length=2**ADDRESS_WIDTH is exact.

## Timing
- Reset values: busy=0, done=0, m_valid=0, m_last=0, m_data=0, mem_addr=0; FIFO empty, pipeline flags cleared, state IDLE.
- Start accepted at edge ending cycle T: mem_addr=base_addr in T+1, mem_dout valid in T+2, m_valid first high in T+3.
- m_ready held 1: one word per cycle sustained, no bubbles after the first.
- m_ready=0: m_valid, m_data, m_last held stable; issue stalls at 4 outstanding, so FIFO never overflows.
- done asserted the cycle after the m_last handshake.
- Reset mid-transfer: all reset values next cycle, in-flight and buffered words discarded, no done pulse; next start behaves normally.

## Structure
- Package ram_reader_pkg: state enum (IDLE, ISSUE, DRAIN), FIFO_DEPTH=4 constant.
- Sub-module stream_fifo: 4-entry synchronous FIFO, DATA_WIDTH+1 wide (data+last), sync active-high reset, push/pop/full/empty/count.
- Top holds FSM, address/issue counters, outstanding accounting, 2-stage valid pipeline.

## Test plan
- RAM model registered-read, ADDRESS_WIDTH=4, ram[i]=100+i. base=2, length=4, m_ready=1 -> data 102,103,104,105 on consecutive cycles from T+3; m_last only on 105; done one cycle after that handshake.
- Wrap: base=14, length=4 -> mem_addr 14,15,0,1; data 114,115,100,101.
- Backpressure: base=0, length=10, m_ready low 6 cycles mid-transfer then random -> exactly 100..109 in order, m_data stable while stalled, outstanding never exceeds 4.
- length=0 -> done pulse at T+1, m_valid never asserted, busy stays 0; length=16 -> 16 words 100..115, mem_addr wraps to 0.
- start pulsed while busy with base=9 -> ignored, original sequence unchanged.
- reset asserted 2 cycles into a length=8 transfer -> reset values next cycle, no done; new start base=5 length=2 -> 105,106.
